// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and streams it one bit per accepted beat, flagging the final bit.
module piso_serial_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             busy
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             ready_int;
    logic             accept;
    logic             beat;
    logic             out_bit_d;

    // A new word may enter while idle, or on the edge that retires the last bit.
    assign ready_int  = (state == IDLE) | ((state == SHIFT) & ser_last & ser_ready);
    assign data_ready = rstn & ready_int;
    assign accept     = data_valid & ready_int;
    assign beat       = ser_valid & ser_ready;

    always_comb begin
        state_d = state;
        sr_d    = sr;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    sr_d    = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (ser_last) begin
                        cnt_d = '0;
                        if (accept) begin
                            sr_d = data_in;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sr_d  = MSB_FIRST ? (sr << 1) : (sr >> 1);
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        out_bit_d = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
    end

    // Serial outputs are registered from the next-state values so they line up with SR/CNT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            sr        <= sr_d;
            cnt       <= cnt_d;
            ser_valid <= (state_d == SHIFT);
            busy      <= (state_d == SHIFT);
            ser_last  <= (state_d == SHIFT) && (cnt_d == CNT_LAST);
            ser_out   <= (state_d == SHIFT) && out_bit_d;
        end
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: LSB-first and MSB-first WIDTH=8 instances share stimulus,
// a WIDTH=1 instance runs separately; beats are scored against queued expectations.
module tb_piso_serial_tx;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] data_in;
    logic       data_valid;
    logic       ser_ready;
    logic       rdy_l, so_l, sv_l, sl_l, busy_l;
    logic       rdy_m, so_m, sv_m, sl_m, busy_m;
    logic [0:0] d1_in;
    logic       d1_valid, s1_ready;
    logic       rdy1, s1_out, s1_valid, s1_last, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] q_l[$];
    logic [1:0] q_m[$];
    logic [1:0] q_1[$];

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_lsb;  // bit i = i-th bit on the wire, LSB-first instance
        logic [7:0] exp_msb;  // bit i = i-th bit on the wire, MSB-first instance
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rstn(rstn), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy_l), .ser_out(so_l), .ser_valid(sv_l), .ser_last(sl_l),
        .ser_ready(ser_ready), .busy(busy_l));

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rstn(rstn), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy_m), .ser_out(so_m), .ser_valid(sv_m), .ser_last(sl_m),
        .ser_ready(ser_ready), .busy(busy_m));

    piso_serial_tx #(.WIDTH(1), .MSB_FIRST(1'b0)) dut_1 (
        .clk(clk), .rstn(rstn), .data_in(d1_in), .data_valid(d1_valid),
        .data_ready(rdy1), .ser_out(s1_out), .ser_valid(s1_valid), .ser_last(s1_last),
        .ser_ready(s1_ready), .busy(busy1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: beat with no expected entry at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] el, input logic [7:0] em);
        for (int i = 0; i < 8; i++) begin
            q_l.push_back({el[i], (i == 7)});
            q_m.push_back({em[i], (i == 7)});
        end
    endtask

    // Scoreboard: every transferred beat is compared against the head of its queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (sv_l && ser_ready) begin
                if (q_l.size() == 0) unexpected("beat_lsb");
                else chk("beat_lsb", 32'({so_l, sl_l}), 32'(q_l.pop_front()));
            end
            if (sv_m && ser_ready) begin
                if (q_m.size() == 0) unexpected("beat_msb");
                else chk("beat_msb", 32'({so_m, sl_m}), 32'(q_m.pop_front()));
            end
            if (s1_valid && s1_ready) begin
                if (q_1.size() == 0) unexpected("beat_w1");
                else chk("beat_w1", 32'({s1_out, s1_last}), 32'(q_1.pop_front()));
            end
        end
    end

    // One isolated word with SER_READY high: 8 contiguous beats, last on the 8th, then idle.
    task automatic do_word(input logic [7:0] d, input logic [7:0] el, input logic [7:0] em);
        push_word(el, em);
        tick();
        data_in    = d;
        data_valid = 1'b1;
        @(negedge clk);
        chk("ready_idle", 32'({rdy_l, rdy_m}), 32'(2'b11));
        tick();
        data_valid = 1'b0;
        data_in    = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("word_run", 32'({sv_l, sl_l, busy_l, sv_m, sl_m}),
                32'({1'b1, (k == 7), 1'b1, 1'b1, (k == 7)}));
        end
        @(negedge clk);
        chk("word_idle", 32'({sv_l, sl_l, so_l, busy_l, sv_m, busy_m}), 32'(0));
    endtask

    initial begin
        vecs[0] = '{data: 8'h1E, exp_lsb: 8'h1E, exp_msb: 8'h78};
        vecs[1] = '{data: 8'hF0, exp_lsb: 8'hF0, exp_msb: 8'h0F};
        vecs[2] = '{data: 8'hA5, exp_lsb: 8'hA5, exp_msb: 8'hA5};
        vecs[3] = '{data: 8'h01, exp_lsb: 8'h01, exp_msb: 8'h80};
        vecs[4] = '{data: 8'h80, exp_lsb: 8'h80, exp_msb: 8'h01};
        vecs[5] = '{data: 8'h6C, exp_lsb: 8'h6C, exp_msb: 8'h36};

        rstn = 1'b1; data_in = '0; data_valid = 1'b0; ser_ready = 1'b1;
        d1_in = '0; d1_valid = 1'b0; s1_ready = 1'b1;
        #2 rstn = 1'b0;

        // Reset with random inputs: everything held low, including DATA_READY.
        for (int c = 0; c < 3; c++) begin
            tick();
            data_in = 8'($urandom); data_valid = 1'($urandom); ser_ready = 1'($urandom);
            d1_in = 1'($urandom); d1_valid = 1'($urandom); s1_ready = 1'($urandom);
            @(negedge clk);
            chk("reset_outs", 32'({so_l, sv_l, sl_l, busy_l, rdy_l, so_m, sv_m, sl_m, busy_m, rdy_m,
                                   s1_out, s1_valid, s1_last, busy1, rdy1}), 32'(0));
        end
        tick();
        rstn = 1'b1; data_valid = 1'b0; d1_valid = 1'b0; ser_ready = 1'b1; s1_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'({rdy_l, rdy_m, rdy1}), 32'(3'b111));

        for (int i = 0; i < 6; i++) begin
            do_word(vecs[i].data, vecs[i].exp_lsb, vecs[i].exp_msb);
        end

        // Backpressure: stall 3 cycles after beat 2; word completes in 11 valid cycles.
        push_word(8'h1E, 8'h78);
        tick();
        data_in = 8'h1E; data_valid = 1'b1;
        tick();
        data_valid = 1'b0; data_in = 8'($urandom);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'({sv_l, sv_m, sl_l, sl_m}), 32'({1'b1, 1'b1, (k == 11), (k == 11)}));
            if (k >= 3 && k <= 5) begin
                chk("bp_hold", 32'({so_l, sl_l, rdy_l, rdy_m}), 32'(4'b1000));
                chk("bp_cnt", 32'(dut_l.cnt), 32'(2));
            end
            if (k == 2) begin
                tick();
                ser_ready = 1'b0;
            end else if (k == 5) begin
                tick();
                ser_ready = 1'b1;
            end
        end
        @(negedge clk);
        chk("bp_idle", 32'({sv_l, busy_l, sv_m, busy_m}), 32'(0));

        // Back-to-back: two words, DATA_VALID held, no bubble between them.
        push_word(8'h1E, 8'h78);
        push_word(8'hF0, 8'h0F);
        tick();
        data_in = 8'h1E; data_valid = 1'b1;
        tick();
        data_in = 8'hF0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("b2b_run", 32'({sv_l, busy_l, sv_m, rdy_l, rdy_m}),
                32'({1'b1, 1'b1, 1'b1, (k == 8 || k == 16), (k == 8 || k == 16)}));
            if (k == 8) begin
                tick();
                data_valid = 1'b0;
                data_in    = 8'($urandom);
            end
        end
        @(negedge clk);
        chk("b2b_idle", 32'({sv_l, busy_l, sv_m, busy_m}), 32'(0));

        // Reset after beat 3: outputs clear immediately and the word is dropped.
        for (int i = 0; i < 3; i++) begin
            q_l.push_back({vecs[0].exp_lsb[i], 1'b0});
            q_m.push_back({vecs[0].exp_msb[i], 1'b0});
        end
        tick();
        data_in = 8'h1E; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("midreset_outs", 32'({so_l, sv_l, sl_l, busy_l, rdy_l, so_m, sv_m, sl_m, busy_m, rdy_m}),
            32'(0));
        chk("midreset_drained", 32'(q_l.size() + q_m.size()), 32'(0));
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("midreset_quiet", 32'({sv_l, sv_m, rdy_l, rdy_m}), 32'(4'b0011));
        do_word(8'hFF, 8'hFF, 8'hFF);

        // WIDTH=1: three back-to-back words, every beat is a last beat.
        q_1.push_back(2'b11);
        q_1.push_back(2'b01);
        q_1.push_back(2'b11);
        tick();
        d1_in = 1'b1; d1_valid = 1'b1;
        tick();
        d1_in = 1'b0;
        @(negedge clk);
        chk("w1_beat1", 32'({s1_valid, s1_last, busy1, rdy1}), 32'(4'b1111));
        tick();
        d1_in = 1'b1;
        @(negedge clk);
        chk("w1_beat2", 32'({s1_valid, s1_last, busy1, rdy1}), 32'(4'b1111));
        tick();
        d1_valid = 1'b0;
        @(negedge clk);
        chk("w1_beat3", 32'({s1_valid, s1_last, busy1}), 32'(3'b111));
        @(negedge clk);
        chk("w1_idle", 32'({s1_valid, s1_last, s1_out, busy1}), 32'(0));

        @(negedge clk);
        chk("queues_drained", 32'(q_l.size() + q_m.size() + q_1.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
